// File: rtl/robinsun_pkg.sv
// rtl/robinsun_pkg.sv - shared types and Gray step tables for the quadrature generator
package robinsun_pkg;

  typedef enum logic [1:0] {QG_IDLE, QG_CONT, QG_BURST} qg_state_t;

  // Phase is packed as {A, B}.
  typedef logic [1:0] quad_phase_t;

  // Next phase indexed by current phase, two bits per entry, entry i at bits [2i+1:2i].
  // Forward (A leads B): 00->10->11->01->00.
  localparam logic [7:0] QUAD_FWD_NEXT = 8'b01_11_00_10;
  // Reverse is the exact inverse of forward: 00->01->11->10->00.
  localparam logic [7:0] QUAD_REV_NEXT = 8'b10_00_11_01;

  function automatic quad_phase_t quad_next(quad_phase_t cur, logic fwd);
    quad_phase_t nxt;
    if (fwd) nxt = QUAD_FWD_NEXT[{cur, 1'b0} +: 2];
    else     nxt = QUAD_REV_NEXT[{cur, 1'b0} +: 2];
    return nxt;
  endfunction

endpackage

// File: rtl/quad_edge_timer.sv
// rtl/quad_edge_timer.sv - edge interval counter with period/direction latch and terminal strobe
module quad_edge_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  input  logic                dir,
  output logic                tick,
  output logic                dir_l
);

  logic [PERIOD_W-1:0] period_l;
  logic [PERIOD_W-1:0] timer;

  // Terminal count of a nonzero latched period; a zero period never strobes.
  assign tick = enable && (period_l != '0) && (timer == period_l - PERIOD_W'(1));

  // While idle, holding a zero period, or at an edge, the timer restarts and the
  // command is re-sampled; otherwise the in-flight interval runs to completion.
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer    <= '0;
      period_l <= '0;
      dir_l    <= 1'b0;
    end else if (!enable || (period_l == '0) || tick) begin
      timer    <= '0;
      period_l <= period;
      dir_l    <= dir;
    end else begin
      timer    <= timer + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/quad_signal_gen.sv
// rtl/quad_signal_gen.sv - quadrature A/B generator with continuous run and counted bursts
module quad_signal_gen
  import robinsun_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int BURST_W  = 16,
  parameter int POS_W    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                dir,
  input  logic [PERIOD_W-1:0] period,
  input  logic                start,
  input  logic [BURST_W-1:0]  burst_len,
  output logic                outA,
  output logic                outB,
  output logic [POS_W-1:0]    position,
  output logic                busy,
  output logic                done
);

  qg_state_t          state, next_state;
  logic               busy_next, done_next;
  logic               busy_q, done_q;
  logic               tick, dir_l;
  logic               last_edge;
  quad_phase_t        ab_q;
  logic [POS_W-1:0]   pos_q;
  logic [BURST_W-1:0] edge_cnt;
  logic [BURST_W-1:0] burst_len_l;

  quad_edge_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (state != QG_IDLE),
    .period (period),
    .dir    (dir),
    .tick   (tick),
    .dir_l  (dir_l)
  );

  assign last_edge = (edge_cnt == burst_len_l - BURST_W'(1));

  // Mode selection; start wins over run, a zero-length burst completes without going busy.
  always_comb begin
    next_state = state;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    case (state)
      QG_IDLE: begin
        if (start) begin
          if (burst_len == '0) begin
            done_next = 1'b1;
          end else begin
            next_state = QG_BURST;
            busy_next  = 1'b1;
          end
        end else if (run) begin
          next_state = QG_CONT;
        end
      end
      QG_CONT: begin
        if (!run) next_state = QG_IDLE;
      end
      QG_BURST: begin
        busy_next = 1'b1;
        if (tick && last_edge) begin
          next_state = QG_IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: next_state = QG_IDLE;
    endcase
  end

  // State and handshake flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= QG_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= next_state;
      busy_q <= busy_next;
      done_q <= done_next;
    end
  end

  // Phase, position and burst edge counter advance together on each timer strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ab_q        <= 2'b00;
      pos_q       <= '0;
      edge_cnt    <= '0;
      burst_len_l <= '0;
    end else begin
      if (tick) begin
        ab_q  <= quad_next(ab_q, dir_l);
        pos_q <= dir_l ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
      end
      if ((state == QG_IDLE) && start) begin
        edge_cnt    <= '0;
        burst_len_l <= burst_len;
      end else if ((state == QG_BURST) && tick) begin
        edge_cnt    <= edge_cnt + BURST_W'(1);
      end
    end
  end

  assign outA     = ab_q[1];
  assign outB     = ab_q[0];
  assign position = pos_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_quad_signal_gen.sv
// tb/tb_quad_signal_gen.sv - directed self-checking bench for quad_signal_gen
module tb_quad_signal_gen;

  logic        clk;
  logic        reset;
  logic        run;
  logic        dir;
  logic [15:0] period;
  logic        start;
  logic [15:0] burst_len;
  logic        outA;
  logic        outB;
  logic [31:0] position;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Forward Gray order starting from 00; index k holds the phase after k forward edges.
  logic [1:0] fwd_tab [4];

  quad_signal_gen #(
    .PERIOD_W (16),
    .BURST_W  (16),
    .POS_W    (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .dir       (dir),
    .period    (period),
    .start     (start),
    .burst_len (burst_len),
    .outA      (outA),
    .outB      (outB),
    .position  (position),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    fwd_tab[0] = 2'b00;
    fwd_tab[1] = 2'b10;
    fwd_tab[2] = 2'b11;
    fwd_tab[3] = 2'b01;

    reset = 1'b0; run = 1'b0; dir = 1'b1; period = 16'd0; start = 1'b0; burst_len = 16'd0;
    repeat (5) @(negedge clk);
    chk("rst_ab", {30'd0, outA, outB}, 32'd0);
    chk("rst_pos", position, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ab", {30'd0, outA, outB}, 32'd0);

    // Continuous forward, period 4: first edge 4 clocks after entry, then every 4.
    run = 1'b1; dir = 1'b1; period = 16'd4;
    repeat (4) @(negedge clk);
    chk("cont_pre_edge1", {30'd0, outA, outB}, 32'd0);
    @(negedge clk);
    chk("cont_edge1_ab", {30'd0, outA, outB}, {30'd0, fwd_tab[1]});
    chk("cont_edge1_pos", position, 32'd1);
    for (int k = 2; k <= 10; k++) begin
      repeat (3) @(negedge clk);
      chk("cont_hold", {30'd0, outA, outB}, {30'd0, fwd_tab[(k - 1) % 4]});
      @(negedge clk);
      chk("cont_edge_ab", {30'd0, outA, outB}, {30'd0, fwd_tab[k % 4]});
      chk("cont_edge_pos", position, k);
    end
    run = 1'b0;
    @(negedge clk);
    chk("cont_stop_pos", position, 32'd10);
    chk("cont_stop_ab", {30'd0, outA, outB}, 32'd3);

    // Reverse at period 8; period drops to 3 mid-interval and only affects later edges.
    run = 1'b1; dir = 1'b0; period = 16'd8;
    repeat (3) @(negedge clk);
    period = 16'd3;
    repeat (5) @(negedge clk);
    chk("rev_no_early_edge", {30'd0, outA, outB}, 32'd3);
    @(negedge clk);
    chk("rev_edge1_ab", {30'd0, outA, outB}, 32'd2);
    chk("rev_edge1_pos", position, 32'd9);
    repeat (2) @(negedge clk);
    chk("rev_hold3", {30'd0, outA, outB}, 32'd2);
    @(negedge clk);
    chk("rev_edge2_ab", {30'd0, outA, outB}, 32'd0);
    chk("rev_edge2_pos", position, 32'd8);
    repeat (3) @(negedge clk);
    chk("rev_edge3_ab", {30'd0, outA, outB}, 32'd1);
    chk("rev_edge3_pos", position, 32'd7);
    run = 1'b0;
    @(negedge clk);
    chk("rev_stop_ab", {30'd0, outA, outB}, 32'd1);

    // Burst of 6 at period 2 with a start pulse injected mid-burst.
    start = 1'b1; burst_len = 16'd6; period = 16'd2; dir = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("burst_busy_entry", {31'd0, busy}, 32'd1);
    chk("burst_done_entry", {31'd0, done}, 32'd0);
    chk("burst_ab_entry", {30'd0, outA, outB}, 32'd1);
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      if (j == 2) start = 1'b0;
      @(negedge clk);
      chk("burst_ab", {30'd0, outA, outB}, {30'd0, fwd_tab[(3 + j) % 4]});
      chk("burst_pos", position, 32'd7 + j);
      chk("burst_busy", {31'd0, busy}, {31'd0, (j != 6)});
      chk("burst_done", {31'd0, done}, {31'd0, (j == 6)});
      if (j == 1) begin
        start = 1'b1;
        burst_len = 16'd1;
      end
    end
    @(negedge clk);
    chk("burst_done_pulse_end", {31'd0, done}, 32'd0);
    chk("burst_busy_end", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("burst_no_extra_ab", {30'd0, outA, outB}, 32'd2);
    chk("burst_no_extra_pos", position, 32'd13);

    // Zero-length burst: done next cycle, busy never asserts, no edges.
    start = 1'b1; burst_len = 16'd0; period = 16'd2;
    @(negedge clk);
    start = 1'b0;
    chk("zlen_done", {31'd0, done}, 32'd1);
    chk("zlen_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("zlen_done_clr", {31'd0, done}, 32'd0);
    chk("zlen_busy_clr", {31'd0, busy}, 32'd0);
    chk("zlen_pos", position, 32'd13);

    // Zero period holds; switching to period 1 gives an edge every clock.
    run = 1'b1; period = 16'd0; dir = 1'b1;
    repeat (10) @(negedge clk);
    chk("p0_ab", {30'd0, outA, outB}, 32'd2);
    chk("p0_pos", position, 32'd13);
    period = 16'd1;
    @(negedge clk);
    chk("p1_latch_ab", {30'd0, outA, outB}, 32'd2);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("p1_ab", {30'd0, outA, outB}, {30'd0, fwd_tab[(1 + i) % 4]});
      chk("p1_pos", position, 32'd13 + i);
    end
    run = 1'b0; period = 16'd0;
    repeat (2) @(negedge clk);

    // Reset asserted mid-burst aborts with no done pulse.
    start = 1'b1; burst_len = 16'd5; period = 16'd3; dir = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd1);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ab", {30'd0, outA, outB}, 32'd0);
    chk("abort_pos", position, 32'd0);
    chk("abort_busy_clr", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
      chk("abort_idle_busy", {31'd0, busy}, 32'd0);
    end

    // Single reverse edge from zero wraps position to all ones.
    start = 1'b1; burst_len = 16'd1; period = 16'd1; dir = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("wrap_busy", {31'd0, busy}, 32'd1);
    chk("wrap_pre_ab", {30'd0, outA, outB}, 32'd0);
    @(negedge clk);
    chk("wrap_ab", {30'd0, outA, outB}, 32'd1);
    chk("wrap_pos", position, 32'hFFFF_FFFF);
    chk("wrap_done", {31'd0, done}, 32'd1);
    chk("wrap_busy_clr", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
